uart_rx_ctrl: RTL and testbench

//  Control/buffer block around the UART receiver core. Owns the receiver's configuration
//  (prescale, parity enable/type) and applies new settings only between frames. Also gates
//  the receiver on/off, buffers received bytes in a small FIFO with valid/ready output, and

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control block.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_IDLE = 2'd2,
    ST_RECV = 2'd3
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Only the oversampling factors the receiver core supports.
  function automatic logic legal_prescale(input logic [31:0] p);
    return (p == 32'(PRESCALE_8)) || (p == 32'(PRESCALE_16)) || (p == 32'(PRESCALE_32));
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a registered head word. The head register holds
// its last value once the FIFO drains, so dout never shows stale slots.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  push_acc, pop_acc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = head_q;

  // Pointer advance and next head; a push into the slot that becomes the
  // head this cycle bypasses the memory.
  always_comb begin
    pop_acc  = pop && !empty;
    push_acc = push && (!full || pop_acc);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_acc);
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d)
      head_d = (push_acc && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d[AW-1:0]];
  end

  // Pointer and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver control: enable sequencing, between-frame config updates, receive
// buffering and sticky error/overrun bookkeeping.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int SCALE_WIDTH = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctrl_en,
  input  logic                   cfg_wr,
  input  logic [SCALE_WIDTH-1:0] cfg_prescale,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_typ,
  input  logic                   clr_status,
  input  logic                   rx_busy,
  input  logic                   rx_data_vld,
  input  logic [DATA_WIDTH-1:0]  rx_p_data,
  input  logic                   rx_par_err,
  input  logic                   rx_stp_err,
  output logic                   rx_enable,
  output logic [SCALE_WIDTH-1:0] rx_prescale,
  output logic                   rx_par_en,
  output logic                   rx_par_typ,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   cfg_pending,
  output logic                   sts_par_err,
  output logic                   sts_stp_err,
  output logic                   sts_ovr,
  output logic                   sts_cfg_err,
  output logic [CNT_WIDTH-1:0]   par_err_cnt,
  output logic [CNT_WIDTH-1:0]   stp_err_cnt,
  output logic [CNT_WIDTH-1:0]   ovr_cnt
);

  rx_state_t              state_q;
  logic                   rx_enable_q, rx_par_en_q, rx_par_typ_q;
  logic [SCALE_WIDTH-1:0] rx_prescale_q;
  logic [SCALE_WIDTH-1:0] sh_prescale_q, sh_prescale_d;
  logic                   sh_par_en_q, sh_par_en_d, sh_par_typ_q, sh_par_typ_d;
  logic                   cfg_pending_q, cfg_pending_d;
  logic                   sts_par_q, sts_par_d, sts_stp_q, sts_stp_d;
  logic                   sts_ovr_q, sts_ovr_d, sts_cfg_q, sts_cfg_d;
  logic [CNT_WIDTH-1:0]   par_cnt_q, par_cnt_d, stp_cnt_q, stp_cnt_d, ovr_cnt_q, ovr_cnt_d;
  logic                   fifo_full, fifo_empty, cfg_ok, cfg_bad, ovr_evt;

  // An event in the same cycle as a clear leaves the counter at 1.
  function automatic logic [CNT_WIDTH-1:0] cnt_upd(input logic [CNT_WIDTH-1:0] c,
                                                   input logic ev, input logic clr);
    if (ev) return clr ? CNT_WIDTH'(1) : ((&c) ? c : c + CNT_WIDTH'(1));
    return clr ? '0 : c;
  endfunction

  uart_rx_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_data_vld),
    .din   (rx_p_data),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (out_data)
  );

  assign cfg_ok  = cfg_wr && legal_prescale(32'(cfg_prescale));
  assign cfg_bad = cfg_wr && !cfg_ok;
  assign ovr_evt = rx_data_vld && fifo_full && !out_ready;

  // Shadow config, pending flag and status bookkeeping.
  always_comb begin
    sh_prescale_d = sh_prescale_q;
    sh_par_en_d   = sh_par_en_q;
    sh_par_typ_d  = sh_par_typ_q;
    cfg_pending_d = cfg_pending_q;
    if (state_q == ST_LOAD) cfg_pending_d = 1'b0;
    if (cfg_ok) begin
      sh_prescale_d = cfg_prescale;
      sh_par_en_d   = cfg_par_en;
      sh_par_typ_d  = cfg_par_typ;
      cfg_pending_d = 1'b1;
    end
    sts_par_d = rx_par_err || (sts_par_q && !clr_status);
    sts_stp_d = rx_stp_err || (sts_stp_q && !clr_status);
    sts_ovr_d = ovr_evt    || (sts_ovr_q && !clr_status);
    sts_cfg_d = cfg_bad    || (sts_cfg_q && !clr_status);
    par_cnt_d = cnt_upd(par_cnt_q, rx_par_err, clr_status);
    stp_cnt_d = cnt_upd(stp_cnt_q, rx_stp_err, clr_status);
    ovr_cnt_d = cnt_upd(ovr_cnt_q, ovr_evt,    clr_status);
  end

  // Non-FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_prescale_q <= SCALE_WIDTH'(PRESCALE_8);
      sh_par_en_q   <= 1'b0;
      sh_par_typ_q  <= 1'b0;
      cfg_pending_q <= 1'b0;
      sts_par_q     <= 1'b0;
      sts_stp_q     <= 1'b0;
      sts_ovr_q     <= 1'b0;
      sts_cfg_q     <= 1'b0;
      par_cnt_q     <= '0;
      stp_cnt_q     <= '0;
      ovr_cnt_q     <= '0;
    end else begin
      sh_prescale_q <= sh_prescale_d;
      sh_par_en_q   <= sh_par_en_d;
      sh_par_typ_q  <= sh_par_typ_d;
      cfg_pending_q <= cfg_pending_d;
      sts_par_q     <= sts_par_d;
      sts_stp_q     <= sts_stp_d;
      sts_ovr_q     <= sts_ovr_d;
      sts_cfg_q     <= sts_cfg_d;
      par_cnt_q     <= par_cnt_d;
      stp_cnt_q     <= stp_cnt_d;
      ovr_cnt_q     <= ovr_cnt_d;
    end
  end

  // Enable sequencing; config is applied only in LOAD, never mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_OFF;
      rx_enable_q   <= 1'b0;
      rx_prescale_q <= SCALE_WIDTH'(PRESCALE_8);
      rx_par_en_q   <= 1'b0;
      rx_par_typ_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: if (ctrl_en) state_q <= ST_LOAD;
        ST_LOAD: begin
          state_q       <= ST_IDLE;
          rx_enable_q   <= 1'b1;
          rx_prescale_q <= sh_prescale_q;
          rx_par_en_q   <= sh_par_en_q;
          rx_par_typ_q  <= sh_par_typ_q;
        end
        ST_IDLE: begin
          if (rx_busy) state_q <= ST_RECV;
          else if (!ctrl_en) begin
            state_q     <= ST_OFF;
            rx_enable_q <= 1'b0;
          end else if (cfg_pending_q) begin
            state_q     <= ST_LOAD;
            rx_enable_q <= 1'b0;
          end
        end
        ST_RECV: if (!rx_busy) state_q <= ST_IDLE;
        default: begin
          state_q     <= ST_OFF;
          rx_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_enable   = rx_enable_q;
  assign rx_prescale = rx_prescale_q;
  assign rx_par_en   = rx_par_en_q;
  assign rx_par_typ  = rx_par_typ_q;
  assign out_valid   = !fifo_empty;
  assign cfg_pending = cfg_pending_q;
  assign sts_par_err = sts_par_q;
  assign sts_stp_err = sts_stp_q;
  assign sts_ovr     = sts_ovr_q;
  assign sts_cfg_err = sts_cfg_q;
  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
  assign ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scenario bench for uart_rx_ctrl with a scoreboard on the receive buffer.
module tb_uart_rx_ctrl;

  localparam int SW = 6, DW = 8, DEPTH = 4, CW = 8;

  logic          clk = 1'b0;
  logic          reset, ctrl_en, cfg_wr, cfg_par_en, cfg_par_typ, clr_status;
  logic [SW-1:0] cfg_prescale;
  logic          rx_busy, rx_data_vld, rx_par_err, rx_stp_err, out_ready;
  logic [DW-1:0] rx_p_data;
  logic          rx_enable, rx_par_en, rx_par_typ, out_valid, cfg_pending;
  logic [SW-1:0] rx_prescale;
  logic [DW-1:0] out_data;
  logic          sts_par_err, sts_stp_err, sts_ovr, sts_cfg_err;
  logic [CW-1:0] par_err_cnt, stp_err_cnt, ovr_cnt;

  int            total = 0, bad = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_pop = '0;
  int            exp_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.SCALE_WIDTH(SW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
    .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .clr_status(clr_status),
    .rx_busy(rx_busy), .rx_data_vld(rx_data_vld), .rx_p_data(rx_p_data),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rx_enable(rx_enable),
    .rx_prescale(rx_prescale), .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cfg_pending(cfg_pending), .sts_par_err(sts_par_err), .sts_stp_err(sts_stp_err),
    .sts_ovr(sts_ovr), .sts_cfg_err(sts_cfg_err), .par_err_cnt(par_err_cnt),
    .stp_err_cnt(stp_err_cnt), .ovr_cnt(ovr_cnt)
  );

  // One clock: update the buffer model from the inputs about to be sampled,
  // score any handshake, then advance to just after the edge.
  task automatic tick();
    logic ovr_now;
    ovr_now = 1'b0;
    if (reset) begin
      sb.delete();
      exp_ovr = 0;
    end else begin
      if (out_ready && sb.size() > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== sb[0]) begin
          bad++;
          $display("FAIL pop_data got vld=%b data=%h want data=%h", out_valid, out_data, sb[0]);
        end
        last_pop = sb.pop_front();
      end
      if (rx_data_vld) begin
        if (sb.size() < DEPTH) sb.push_back(rx_p_data);
        else ovr_now = 1'b1;
      end
      if (clr_status) exp_ovr = ovr_now ? 1 : 0;
      else if (ovr_now && exp_ovr < 255) exp_ovr++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if (rx_enable !== 1'b0 || rx_prescale !== 6'd8 || rx_par_en !== 1'b0 || rx_par_typ !== 1'b0 ||
        out_valid !== 1'b0 || out_data !== 8'h00 || cfg_pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b ps=%0d pe=%b pt=%b vld=%b data=%h pend=%b want 0/8/0/0/0/00/0",
               rx_enable, rx_prescale, rx_par_en, rx_par_typ, out_valid, out_data, cfg_pending);
    end
    total++;
    if ({sts_par_err, sts_stp_err, sts_ovr, sts_cfg_err} !== 4'b0 ||
        par_err_cnt !== 8'd0 || stp_err_cnt !== 8'd0 || ovr_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_status got flags=%b%b%b%b cnt=%0d/%0d/%0d want all 0",
               sts_par_err, sts_stp_err, sts_ovr, sts_cfg_err, par_err_cnt, stp_err_cnt, ovr_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    ctrl_en = 1'b1;
    tick();
    total++;
    if (rx_enable !== 1'b0) begin bad++; $display("FAIL load_cycle_en got=%b want=0", rx_enable); end
    tick();
    total++;
    if (rx_enable !== 1'b1 || rx_prescale !== 6'd8) begin
      bad++; $display("FAIL enabled got en=%b ps=%0d want en=1 ps=8", rx_enable, rx_prescale);
    end
  endtask

  task automatic test_cfg();
    rx_busy = 1'b1;
    tick();
    cfg_wr = 1'b1; cfg_prescale = 6'd16;
    tick();
    cfg_wr = 1'b0;
    tick(); tick();
    total++;
    if (rx_prescale !== 6'd8 || rx_enable !== 1'b1 || cfg_pending !== 1'b1) begin
      bad++; $display("FAIL cfg_hold_in_frame got ps=%0d en=%b pend=%b want 8/1/1", rx_prescale, rx_enable, cfg_pending);
    end
    rx_busy = 1'b0;
    tick();
    tick();
    total++;
    if (rx_enable !== 1'b0 || rx_prescale !== 6'd8) begin
      bad++; $display("FAIL cfg_load_cycle got en=%b ps=%0d want en=0 ps=8", rx_enable, rx_prescale);
    end
    tick();
    total++;
    if (rx_enable !== 1'b1 || rx_prescale !== 6'd16 || cfg_pending !== 1'b0) begin
      bad++; $display("FAIL cfg_applied got en=%b ps=%0d pend=%b want 1/16/0", rx_enable, rx_prescale, cfg_pending);
    end
    cfg_wr = 1'b1; cfg_prescale = 6'd12;
    tick();
    cfg_wr = 1'b0;
    tick();
    total++;
    if (sts_cfg_err !== 1'b1 || cfg_pending !== 1'b0 || rx_prescale !== 6'd16 || rx_enable !== 1'b1) begin
      bad++; $display("FAIL cfg_illegal got err=%b pend=%b ps=%0d en=%b want 1/0/16/1",
                      sts_cfg_err, cfg_pending, rx_prescale, rx_enable);
    end
    // A write landing in the LOAD cycle is kept for a later LOAD.
    cfg_wr = 1'b1; cfg_prescale = 6'd32; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    cfg_wr = 1'b1; cfg_prescale = 6'd8; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    tick();
    cfg_wr = 1'b0;
    total++;
    if (rx_prescale !== 6'd32 || rx_par_en !== 1'b1 || rx_par_typ !== 1'b1 || cfg_pending !== 1'b1) begin
      bad++; $display("FAIL cfg_wr_during_load got ps=%0d pe=%b pt=%b pend=%b want 32/1/1/1",
                      rx_prescale, rx_par_en, rx_par_typ, cfg_pending);
    end
    tick(); tick();
    total++;
    if (rx_prescale !== 6'd8 || rx_par_en !== 1'b0 || cfg_pending !== 1'b0 || rx_enable !== 1'b1) begin
      bad++; $display("FAIL cfg_second_load got ps=%0d pe=%b pend=%b en=%b want 8/0/0/1",
                      rx_prescale, rx_par_en, cfg_pending, rx_enable);
    end
  endtask

  task automatic test_overrun();
    int n;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rx_data_vld = 1'b1; rx_p_data = 8'(8'h11 * i);
      tick();
      if (i == 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
          bad++; $display("FAIL push_latency got vld=%b data=%h want 1/11", out_valid, out_data);
        end
      end
    end
    rx_data_vld = 1'b0;
    tick();
    total++;
    if (sts_ovr !== 1'b1 || ovr_cnt !== 8'(exp_ovr)) begin
      bad++; $display("FAIL overrun got flag=%b cnt=%0d want 1/%0d", sts_ovr, ovr_cnt, exp_ovr);
    end
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 10) begin tick(); n++; end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d want 0", sb.size()); end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== last_pop) begin
      bad++; $display("FAIL empty_hold got vld=%b data=%h want 0/%h", out_valid, out_data, last_pop);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    int n;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_data_vld = 1'b1; rx_p_data = 8'(8'hA1 + i);
      tick();
    end
    rx_p_data = 8'h66; out_ready = 1'b1;
    tick();
    rx_data_vld = 1'b0; out_ready = 1'b0;
    tick();
    total++;
    if (sts_ovr !== 1'b0 || ovr_cnt !== 8'(exp_ovr) || out_valid !== 1'b1) begin
      bad++; $display("FAIL full_push_pop got ovr=%b cnt=%0d vld=%b want 0/%0d/1", sts_ovr, ovr_cnt, out_valid, exp_ovr);
    end
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 10) begin tick(); n++; end
    out_ready = 1'b0;
    total++;
    if (sb.size() != 0 || last_pop !== 8'h66) begin
      bad++; $display("FAIL full_drain got left=%0d last=%h want 0/66", sb.size(), last_pop);
    end
  endtask

  task automatic test_counters();
    int exp_par;
    exp_par = 0;
    rx_par_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_par < 255) exp_par++;
    end
    rx_par_err = 1'b0;
    tick();
    total++;
    if (par_err_cnt !== 8'(exp_par) || sts_par_err !== 1'b1) begin
      bad++; $display("FAIL par_saturate got cnt=%0d flag=%b want %0d/1", par_err_cnt, sts_par_err, exp_par);
    end
    clr_status = 1'b1; rx_stp_err = 1'b1;
    tick();
    clr_status = 1'b0; rx_stp_err = 1'b0;
    total++;
    if (stp_err_cnt !== 8'd1 || sts_stp_err !== 1'b1 || par_err_cnt !== 8'd0 || sts_par_err !== 1'b0 ||
        ovr_cnt !== 8'd0 || sts_cfg_err !== 1'b0) begin
      bad++; $display("FAIL clr_vs_event got stp=%0d/%b par=%0d/%b ovr=%0d cfg=%b want 1/1 0/0 0 0",
                      stp_err_cnt, sts_stp_err, par_err_cnt, sts_par_err, ovr_cnt, sts_cfg_err);
    end
    rx_stp_err = 1'b1;
    tick();
    rx_stp_err = 1'b0;
    tick();
    total++;
    if (stp_err_cnt !== 8'd2) begin bad++; $display("FAIL stp_increment got=%0d want=2", stp_err_cnt); end
  endtask

  task automatic test_ctrl_drop_and_reset();
    rx_busy = 1'b1;
    tick();
    ctrl_en = 1'b0;
    tick(); tick();
    total++;
    if (rx_enable !== 1'b1) begin bad++; $display("FAIL drop_mid_frame got en=%b want=1", rx_enable); end
    rx_busy = 1'b0;
    tick(); tick();
    total++;
    if (rx_enable !== 1'b0) begin bad++; $display("FAIL drop_to_off got en=%b want=0", rx_enable); end
    ctrl_en = 1'b1;
    tick(); tick();
    cfg_wr = 1'b1; cfg_prescale = 6'd16; rx_data_vld = 1'b1; rx_p_data = 8'h5A;
    rx_busy = 1'b1; rx_par_err = 1'b1;
    tick();
    cfg_wr = 1'b0; rx_data_vld = 1'b0; rx_par_err = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (rx_enable !== 1'b0 || rx_prescale !== 6'd8 || cfg_pending !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || par_err_cnt !== 8'd0 || sts_par_err !== 1'b0 || sts_cfg_err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_frame got en=%b ps=%0d pend=%b vld=%b data=%h pcnt=%0d pflag=%b cfg=%b want 0/8/0/0/00/0/0/0",
                      rx_enable, rx_prescale, cfg_pending, out_valid, out_data, par_err_cnt, sts_par_err, sts_cfg_err);
    end
    reset = 1'b0; ctrl_en = 1'b0; rx_busy = 1'b0;
    tick();
    total++;
    if (rx_enable !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL after_reset got en=%b vld=%b want 0/0", rx_enable, out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_en = 1'b0; cfg_wr = 1'b0; cfg_prescale = 6'd8; cfg_par_en = 1'b0;
    cfg_par_typ = 1'b0; clr_status = 1'b0; rx_busy = 1'b0; rx_data_vld = 1'b0;
    rx_p_data = '0; rx_par_err = 1'b0; rx_stp_err = 1'b0; out_ready = 1'b0;
    test_reset();
    test_enable();
    test_cfg();
    test_overrun();
    test_full_push_pop();
    test_counters();
    test_ctrl_drop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
